// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - Issue/result handshake bundle for the EX-stage execution unit.
interface alu_exec_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            Operation;
  logic [DATA_WIDTH-1:0] SrcA;
  logic [DATA_WIDTH-1:0] SrcB;
  logic [4:0]            in_rd;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] ALUResult;
  logic                  BranchTaken;
  logic [4:0]            out_rd;
  logic                  busy;

  modport master (
    output flush, in_valid, Operation, SrcA, SrcB, in_rd, out_ready,
    input  in_ready, out_valid, ALUResult, BranchTaken, out_rd, busy
  );

  modport slave (
    input  flush, in_valid, Operation, SrcA, SrcB, in_rd, out_ready,
    output in_ready, out_valid, ALUResult, BranchTaken, out_rd, busy
  );
endinterface

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - EX-stage ALU: single-cycle logic/add/compare, iterative shifts, valid/ready on both sides.
module alu_exec_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic            clk,
  input  logic            reset,
  alu_exec_unit_if.slave  bus
);
  localparam int SHW = $clog2(DATA_WIDTH);
  localparam logic [SHW-1:0] STEP_W = SHW'(SHIFT_STEP);

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010, OP_SUB = 4'b0011,
                         OP_XOR = 4'b0100, OP_SRL = 4'b0101, OP_SLL = 4'b0110, OP_SRA = 4'b0111,
                         OP_EQ  = 4'b1000, OP_NE  = 4'b1010, OP_SLT = 4'b1100;

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_next;

  logic [DATA_WIDTH-1:0] alu_res, sh_data, sh_next, result;
  logic [SHW-1:0]        shamt, sh_rem, sh_amt;
  logic [3:0]            sh_op;
  logic [4:0]            sh_rd, rd;
  logic                  alu_br, br, out_valid, is_shift, accept, start_shift, done_shift, in_ready;

  assign shamt       = bus.SrcB[SHW-1:0];
  assign is_shift    = (bus.Operation == OP_SRL) || (bus.Operation == OP_SLL) || (bus.Operation == OP_SRA);
  assign in_ready    = (state == IDLE) && (!out_valid || bus.out_ready) && !bus.flush;
  assign accept      = bus.in_valid && in_ready;
  assign start_shift = accept && is_shift && (shamt != '0);
  assign done_shift  = (state == SHIFT) && (sh_rem == sh_amt);

  // Zero-distance shifts fall through the single-cycle path with result = SrcA.
  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    case (bus.Operation)
      OP_AND:                 alu_res = bus.SrcA & bus.SrcB;
      OP_OR:                  alu_res = bus.SrcA | bus.SrcB;
      OP_ADD:                 alu_res = bus.SrcA + bus.SrcB;
      OP_SUB:                 alu_res = bus.SrcA - bus.SrcB;
      OP_XOR:                 alu_res = bus.SrcA ^ bus.SrcB;
      OP_SRL, OP_SLL, OP_SRA: alu_res = bus.SrcA;
      OP_EQ:                  alu_br  = (bus.SrcA == bus.SrcB);
      OP_NE: begin
        alu_res = bus.SrcB;
        alu_br  = (bus.SrcA != bus.SrcB);
      end
      OP_SLT: alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(bus.SrcA) < $signed(bus.SrcB))};
      default: ;
    endcase
  end

  always_comb begin
    sh_amt = (int'(sh_rem) > SHIFT_STEP) ? STEP_W : sh_rem;
    case (sh_op)
      OP_SRL:  sh_next = sh_data >> sh_amt;
      OP_SLL:  sh_next = sh_data << sh_amt;
      OP_SRA:  sh_next = $signed(sh_data) >>> sh_amt;
      default: sh_next = sh_data;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_shift) state_next = SHIFT;
      SHIFT:   if (done_shift)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.flush) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      br        <= 1'b0;
      rd        <= '0;
      sh_data   <= '0;
      sh_rem    <= '0;
      sh_op     <= '0;
      sh_rd     <= '0;
    end else begin
      if (bus.flush) begin
        out_valid <= 1'b0;
      end else begin
        if (out_valid && bus.out_ready) out_valid <= 1'b0;
        if (accept && !start_shift) begin
          result    <= alu_res;
          br        <= alu_br;
          rd        <= bus.in_rd;
          out_valid <= 1'b1;
        end
        if (done_shift) begin
          result    <= sh_next;
          br        <= 1'b0;
          rd        <= sh_rd;
          out_valid <= 1'b1;
        end
      end
      if (accept) begin
        sh_data <= bus.SrcA;
        sh_rem  <= shamt;
        sh_op   <= bus.Operation;
        sh_rd   <= bus.in_rd;
      end else if (state == SHIFT) begin
        sh_data <= sh_next;
        sh_rem  <= sh_rem - sh_amt;
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.ALUResult   = result;
  assign bus.BranchTaken = br;
  assign bus.out_rd      = rd;
  assign bus.busy        = (state == SHIFT);
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - Scoreboard bench for alu_exec_unit with directed vectors.
module tb_alu_exec_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.DATA_WIDTH(32)) bus ();
  alu_exec_unit #(.DATA_WIDTH(32), .SHIFT_STEP(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [31:0] res;
    logic        br;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation on every transfer, and checks hold stability under backpressure.
  initial begin : monitor
    exp_t e;
    exp_t held;
    logic hold;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && bus.out_valid) begin
        if (hold) begin
          chk("hold_result", bus.ALUResult, held.res);
          chk("hold_branch", 32'(bus.BranchTaken), 32'(held.br));
          chk("hold_rd", 32'(bus.out_rd), 32'(held.rd));
        end
        if (bus.out_ready) begin
          hold = 1'b0;
          if (sb.size() == 0) begin
            chk("unexpected_result", 32'(bus.out_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("result", bus.ALUResult, e.res);
            chk("branch", 32'(bus.BranchTaken), 32'(e.br));
            chk("rd", 32'(bus.out_rd), 32'(e.rd));
          end
        end else begin
          hold = 1'b1;
          held = '{res: bus.ALUResult, br: bus.BranchTaken, rd: bus.out_rd};
        end
      end else begin
        hold = 1'b0;
      end
    end
  end

  task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] er, input logic eb, input int lat, input bit push);
    int n;
    int nb;
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.Operation = op;
    bus.SrcA      = a;
    bus.SrcB      = b;
    bus.in_rd     = rd;
    @(negedge clk);
    for (int w = 0; w < 20 && !bus.in_ready; w++) @(negedge clk);
    chk({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    if (push) sb.push_back('{res: er, br: eb, rd: rd});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (lat > 0) begin
      n  = 0;
      nb = 0;
      do begin
        @(negedge clk);
        n++;
        if (bus.busy) begin
          nb++;
          if (bus.in_ready) chk({name, "_in_ready_while_busy"}, 32'(bus.in_ready), 32'd0);
        end
      end while (!bus.out_valid && n < 40);
      chk({name, "_latency"}, 32'(n), 32'(lat));
      chk({name, "_busy_cycles"}, 32'(nb), 32'(lat - 1));
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic rose;
    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.Operation = '0;
    bus.SrcA      = '0;
    bus.SrcB      = '0;
    bus.in_rd     = '0;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", bus.ALUResult, 32'd0);
    chk("rst_branch", 32'(bus.BranchTaken), 32'd0);
    chk("rst_out_rd", 32'(bus.out_rd), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    issue("add",      4'b0010, 32'd5,        32'd7,        5'd3,  32'd12,        1'b0, 1, 1);
    issue("sub",      4'b0011, 32'd3,        32'd5,        5'd4,  32'hFFFFFFFE,  1'b0, 1, 1);
    issue("add_wrap", 4'b0010, 32'hFFFFFFFF, 32'd2,        5'd1,  32'd1,         1'b0, 1, 1);
    issue("slt_neg",  4'b1100, 32'hFFFFFFFF, 32'd1,        5'd8,  32'd1,         1'b0, 1, 1);
    issue("slt_pos",  4'b1100, 32'd1,        32'hFFFFFFFF, 5'd9,  32'd0,         1'b0, 1, 1);
    issue("slt_eq",   4'b1100, 32'd5,        32'd5,        5'd9,  32'd0,         1'b0, 1, 1);
    issue("eq_t",     4'b1000, 32'd9,        32'd9,        5'd10, 32'd0,         1'b1, 1, 1);
    issue("eq_f",     4'b1000, 32'd9,        32'd8,        5'd11, 32'd0,         1'b0, 1, 1);
    issue("ne_lui",   4'b1010, 32'd1,        32'h12345000, 5'd12, 32'h12345000,  1'b1, 1, 1);
    issue("ne_f",     4'b1010, 32'd7,        32'd7,        5'd13, 32'd7,         1'b0, 1, 1);
    issue("and",      4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd14, 32'h00F000F0,  1'b0, 1, 1);
    issue("or",       4'b0001, 32'hF0000000, 32'h0000000F, 5'd15, 32'hF000000F,  1'b0, 1, 1);
    issue("xor",      4'b0100, 32'hFFFF0000, 32'h0F0F0F0F, 5'd16, 32'hF0F00F0F,  1'b0, 1, 1);
    issue("bad_1111", 4'b1111, 32'd9,        32'd9,        5'd17, 32'd0,         1'b0, 1, 1);
    issue("bad_1001", 4'b1001, 32'd9,        32'd9,        5'd18, 32'd0,         1'b0, 1, 1);

    issue("sra31",    4'b0111, 32'h80000000, 32'd31,       5'd19, 32'hFFFFFFFF,  1'b0, 9, 1);
    issue("srl5",     4'b0101, 32'hF0000000, 32'd5,        5'd20, 32'h07800000,  1'b0, 3, 1);
    issue("sll4",     4'b0110, 32'd1,        32'd4,        5'd21, 32'h00000010,  1'b0, 2, 1);
    issue("sll9",     4'b0110, 32'd3,        32'd9,        5'd22, 32'h00000600,  1'b0, 4, 1);
    issue("sll0",     4'b0110, 32'hDEADBEEF, 32'h20,       5'd23, 32'hDEADBEEF,  1'b0, 1, 1);
    issue("sra4_pos", 4'b0111, 32'h7FFFFFF0, 32'd4,        5'd24, 32'h07FFFFFF,  1'b0, 2, 1);
    issue("srl31",    4'b0101, 32'h80000000, 32'd31,       5'd25, 32'd1,         1'b0, 9, 1);

    // Backpressure then back-to-back accept on the drain cycle.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    issue("bp_add",   4'b0010, 32'd10,       32'd20,       5'd5,  32'd30,        1'b0, 1, 1);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.Operation = 4'b0010;
    bus.SrcA      = 32'd1;
    bus.SrcB      = 32'd1;
    bus.in_rd     = 5'd6;
    @(negedge clk);
    chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
    sb.push_back('{res: 32'd2, br: 1'b0, rd: 5'd6});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_out_valid", 32'(bus.out_valid), 32'd1);

    // Flush in the third SHIFT cycle.
    issue("flush_sll", 4'b0110, 32'd1, 32'd20, 5'd26, 32'd0, 1'b0, -1, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_busy_before", 32'(bus.busy), 32'd1);
    chk("flush_in_ready_low", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_busy", 32'(bus.busy), 32'd0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    rose = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) rose = 1'b1;
    end
    chk("flush_no_result", 32'(rose), 32'd0);
    issue("post_flush", 4'b0010, 32'd100, 32'd23, 5'd27, 32'd123, 1'b0, 1, 1);

    // Async reset in the middle of a shift, with a nonzero result still held.
    issue("pre_rst_ne", 4'b1010, 32'd1, 32'h12345000, 5'd7, 32'h12345000, 1'b1, 1, 1);
    issue("rst_sra",    4'b0111, 32'h80000000, 32'd31, 5'd28, 32'd0, 1'b0, -1, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mid_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_result", bus.ALUResult, 32'd0);
    chk("rst_mid_branch", 32'(bus.BranchTaken), 32'd0);
    chk("rst_mid_out_rd", 32'(bus.out_rd), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #2;
    reset = 1'b0;
    issue("post_rst",  4'b0011, 32'd50, 32'd8, 5'd29, 32'd42, 1'b0, 1, 1);
    issue("post_rst_sll", 4'b0110, 32'd1, 32'd8, 5'd30, 32'h100, 1'b0, 3, 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
